dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache for the RISC-V pipeline CPU. It sits in the combined MEM/WB stage between the pipeline's load/store path and word-serial main memory. It produces `DCacheMiss`, which the hazard unit uses to stall the whole pipeline until the access completes. Hits complete in the request cycle. Misses run a writeback/refill state machine.

---
 rtl/dcache_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with a word-serial writeback/refill FSM.
// Define DCACHE_STATS_EN to add the saturating hit_cnt/miss_cnt counter outputs.
module dcache_ctrl #(
    parameter int SET_LOG  = 4,
    parameter int LINE_LOG = 2
) (
    input  logic        clk,
    input  logic        CpuRst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wbe,
    output logic [31:0] rdata,
    output logic        DCacheMiss,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int TAG_W = 32 - 2 - LINE_LOG - SET_LOG;
    localparam int SETS  = 1 << SET_LOG;
    localparam int WORDS = 1 << LINE_LOG;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_e;

    state_e              state_q;
    logic [LINE_LOG-1:0] cnt_q;
    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;
    logic                mem_rd_q;
    logic                mem_wr_q;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [31:0]         data_q [SETS][WORDS];

    logic [TAG_W-1:0]    a_tag;
    logic [SET_LOG-1:0]  a_idx;
    logic [LINE_LOG-1:0] a_off;
    logic                req;
    logic                hit;
    logic                idle;
    logic                cnt_last;
    logic                wr_hit;
    logic                fill_ack;
    logic                unused_addr_lo;

    assign a_tag          = addr[31 -: TAG_W];
    assign a_idx          = addr[2+LINE_LOG +: SET_LOG];
    assign a_off          = addr[2 +: LINE_LOG];
    assign unused_addr_lo = ^addr[1:0];

    assign req      = rd_req | wr_req;
    assign hit      = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
    assign idle     = (state_q == IDLE);
    assign cnt_last = (cnt_q == {LINE_LOG{1'b1}});
    // A simultaneous read+write is treated as a store.
    assign wr_hit   = idle && wr_req && hit;
    assign fill_ack = (state_q == FILL) && mem_ack;

    assign DCacheMiss = (req && !hit) || !idle;
    assign rdata      = (rd_req && !DCacheMiss) ? data_q[a_idx][a_off] : '0;
    assign mem_rd_req = mem_rd_q;
    assign mem_wr_req = mem_wr_q;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            WB: begin
                mem_addr  = {tag_q[a_idx], a_idx, cnt_q, 2'b00};
                mem_wdata = data_q[a_idx][cnt_q];
            end
            FILL: mem_addr = {a_tag, a_idx, cnt_q, 2'b00};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge CpuRst_n) begin
        if (!CpuRst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        if (wr_req) dirty_q[a_idx] <= 1'b1;
                    end else if (req) begin
                        cnt_q <= '0;
                        if (dirty_q[a_idx]) begin
                            state_q  <= WB;
                            mem_wr_q <= 1'b1;
                        end else begin
                            state_q  <= FILL;
                            mem_rd_q <= 1'b1;
                        end
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        cnt_q <= cnt_q + LINE_LOG'(1);
                        if (cnt_last) begin
                            dirty_q[a_idx] <= 1'b0;
                            cnt_q          <= '0;
                            state_q        <= FILL;
                            mem_wr_q       <= 1'b0;
                            mem_rd_q       <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        cnt_q <= cnt_q + LINE_LOG'(1);
                        // Valid only goes up once every word is in, so an aborted fill leaves the line invalid.
                        if (cnt_last) begin
                            valid_q[a_idx] <= 1'b1;
                            dirty_q[a_idx] <= 1'b0;
                            cnt_q          <= '0;
                            state_q        <= IDLE;
                            mem_rd_q       <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe[b]) data_q[a_idx][a_off][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (fill_ack) begin
            data_q[a_idx][cnt_q] <= mem_rdata;
            if (cnt_last) tag_q[a_idx] <= a_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or negedge CpuRst_n) begin
        if (!CpuRst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (idle && req && hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (idle && req && !hit && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized self-checking bench for dcache_ctrl: flat golden memory plus a line-residency model
// predicting stall length, writeback/refill traffic and load data.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        CpuRst_n;
    logic        rd_req, wr_req;
    logic [31:0] addr, wdata;
    logic [3:0]  wbe;
    logic [31:0] rdata;
    logic        DCacheMiss;
    logic        mem_rd_req, mem_wr_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack   = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    dcache_ctrl dut (
        .clk       (clk),
        .CpuRst_n  (CpuRst_n),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .addr      (addr),
        .wdata     (wdata),
        .wbe       (wbe),
        .rdata     (rdata),
        .DCacheMiss(DCacheMiss),
        .mem_rd_req(mem_rd_req),
        .mem_wr_req(mem_wr_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Backing memory (what main memory holds) and golden memory (what the CPU must observe).
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] gmem [logic [31:0]];
    bit          rvalid [16];
    bit          rdirty [16];
    logic [23:0] rtag   [16];

    logic [31:0] fill_q [$];
    logic [31:0] wb_q   [$];
    int          ack_gap   = 1;
    int          wcnt      = 0;
    int          ack_n     = 0;
    int          addr_chg  = 0;
    int          both_hi   = 0;
    bit          force_ack = 1'b0;
    logic [31:0] held_addr = 32'h0;

    function automatic logic [31:0] def_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] bread(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : def_word(a);
    endfunction

    function automatic logic [31:0] gval(input logic [31:0] a);
        return gmem.exists(a) ? gmem[a] : bread(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        bmem[a] = v;
        gmem[a] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            rvalid[i] = 1'b0;
            rdirty[i] = 1'b0;
            rtag[i]   = '0;
        end
        gmem = bmem;
    endtask

    // Word-serial memory: acks on the ack_gap-th cycle a strobe has been held.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_rd_req && mem_wr_req) both_hi++;
        if (mem_rd_req || mem_wr_req) begin
            if (wcnt > 0 && mem_addr != held_addr) addr_chg++;
            held_addr = mem_addr;
            wcnt++;
            if (wcnt >= ack_gap) begin
                mem_ack = 1'b1;
                wcnt    = 0;
                ack_n++;
                if (mem_rd_req) begin
                    mem_rdata = bread(mem_addr);
                    fill_q.push_back(mem_addr);
                end else begin
                    bmem[mem_addr] = mem_wdata;
                    wb_q.push_back(mem_addr);
                end
            end
        end else begin
            wcnt    = 0;
            mem_ack = force_ack;
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input string nm, output logic [31:0] rdv);
        logic [31:0] wa, old_base, new_base, cur;
        logic [23:0] tg;
        int          idx, exp_stall, stall;
        bit          hit, evd;
        wa        = {a[31:2], 2'b00};
        idx       = int'(a[7:4]);
        tg        = a[31:8];
        hit       = rvalid[idx] && rtag[idx] == tg;
        evd       = !hit && rdirty[idx];
        old_base  = {rtag[idx], a[7:4], 4'h0};
        new_base  = {tg, a[7:4], 4'h0};
        exp_stall = hit ? 0 : 1 + 4 * ack_gap + (evd ? 4 * ack_gap : 0);
        fill_q.delete();
        wb_q.delete();
        rd_req = rd;
        wr_req = wr;
        addr   = a;
        wdata  = wd;
        wbe    = be;
        stall  = 0;
        rdv    = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!DCacheMiss) begin
                rdv = rdata;
                break;
            end
            stall++;
            if (stall > 200) begin
                chk({nm, ":timeout"}, 32'(DCacheMiss), 32'h0);
                break;
            end
        end
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        chk({nm, ":stall"}, stall, exp_stall);
        if (rd && !wr) chk({nm, ":rdata"}, rdv, gval(wa));
        chk({nm, ":fills"}, fill_q.size(), hit ? 0 : 4);
        if (!hit) begin
            for (int i = 0; i < 4 && i < fill_q.size(); i++)
                chk({nm, ":fill_addr"}, fill_q[i], new_base + 32'(4 * i));
        end
        chk({nm, ":wbs"}, wb_q.size(), evd ? 4 : 0);
        if (evd) begin
            for (int i = 0; i < 4 && i < wb_q.size(); i++) begin
                chk({nm, ":wb_addr"}, wb_q[i], old_base + 32'(4 * i));
                chk({nm, ":wb_data"}, bread(old_base + 32'(4 * i)), gval(old_base + 32'(4 * i)));
            end
        end
        if (!hit) begin
            rvalid[idx] = 1'b1;
            rtag[idx]   = tg;
            rdirty[idx] = 1'b0;
        end
        if (wr) begin
            cur = gval(wa);
            for (int b = 0; b < 4; b++)
                if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
            gmem[wa]    = cur;
            rdirty[idx] = 1'b1;
        end
    endtask

    logic [31:0] rdv;
    logic [31:0] ra;
    bit          rrd, rwr;
    int          base_ack, guard;
    logic [23:0] tagpool [4] = '{24'h000001, 24'h000011, 24'h000022, 24'h0000A5};

    initial begin
        CpuRst_n = 1'b0;
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        addr     = '0;
        wdata    = '0;
        wbe      = '0;
        model_reset();
        #3;
        chk("rst_miss", 32'(DCacheMiss), 32'h0);
        chk("rst_rd_req", 32'(mem_rd_req), 32'h0);
        chk("rst_wr_req", 32'(mem_wr_req), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
`ifdef DCACHE_STATS_EN
        chk("rst_hit_cnt", hit_cnt, 32'h0);
        chk("rst_miss_cnt", miss_cnt, 32'h0);
`endif
        @(posedge clk);
        #1;
        CpuRst_n = 1'b1;

        for (int i = 0; i < 4; i++) preload(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        ack_gap = 1;
        access(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, "cold", rdv);
        chk("cold_word0", rdv, 32'h0000_00A0);
        access(1'b0, 1'b1, 32'h104, 32'h1122_3344, 4'b0011, "wr_hit", rdv);
        access(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, "rd_merge", rdv);
        chk("merge_word", rdv, 32'h0000_3344);
        access(1'b1, 1'b0, 32'h1100, 32'h0, 4'h0, "evict", rdv);
        chk("evict_mem104", bread(32'h104), 32'h0000_3344);
`ifdef DCACHE_STATS_EN
        chk("stats_hit", hit_cnt, 32'd4);
        chk("stats_miss", miss_cnt, 32'd2);
`endif

        ack_gap  = 3;
        addr_chg = 0;
        access(1'b1, 1'b0, 32'h2200, 32'h0, 4'h0, "slow", rdv);
        chk("slow_addr_stable", addr_chg, 32'h0);

        // Reset in the middle of a refill, then a stray ack right after release.
        ack_gap  = 1;
        base_ack = ack_n;
        guard    = 0;
        addr     = 32'h340;
        rd_req   = 1'b1;
        while (ack_n - base_ack < 2 && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("rst_two_acks", ack_n - base_ack, 32'd2);
        @(posedge clk);
        #1;
        CpuRst_n = 1'b0;
        rd_req   = 1'b0;
        #1;
        chk("midrst_rd_req", 32'(mem_rd_req), 32'h0);
        chk("midrst_wr_req", 32'(mem_wr_req), 32'h0);
        chk("midrst_addr", mem_addr, 32'h0);
        chk("midrst_miss", 32'(DCacheMiss), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        CpuRst_n  = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        chk("stray_strobes", 32'(mem_rd_req | mem_wr_req), 32'h0);
        chk("stray_miss", 32'(DCacheMiss), 32'h0);
        access(1'b1, 1'b0, 32'h340, 32'h0, 4'h0, "rst_refill", rdv);

        for (int k = 0; k < 300; k++) begin
            ra      = {tagpool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
            rrd     = 1'($urandom_range(0, 1));
            rwr     = 1'($urandom_range(0, 1));
            if (!rrd && !rwr) rrd = 1'b1;
            ack_gap = $urandom_range(1, 3);
            access(rrd, rwr, ra, $urandom, 4'($urandom_range(0, 15)), "rand", rdv);
        end
        chk("strobe_exclusive", both_hi, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
